azimuth_sweep_scheduler: RTL and testbench

- Sequences the azimuth signal generator across one antenna revolution, driving its EN, TRIG and DATA inputs.
- Assembles per-azimuth range bitmaps (SIZE bits) from a 32-bit AXI-Stream fed by the DMA FIFO into a shadow buffer.
- Swaps the shadow buffer into the generator's DATA on every azimuth change pulse (ACP) and tracks azimuth from ACP/ARP (north reference).
- Reports underrun and framing errors to software.

---
 rtl/azimuth_sweep_scheduler_if.sv | 14 +
 rtl/azimuth_sweep_scheduler.sv | 130 +++++++++++++
 tb/tb_azimuth_sweep_scheduler.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/azimuth_sweep_scheduler_if.sv
// Bitmap word stream from the DMA FIFO into the azimuth sweep scheduler.
// A word transfers on a rising clock edge where tvalid and tready are both high.
// The master holds tdata/tlast stable while tvalid is high and tready is low.
interface azimuth_sweep_scheduler_if #(
  parameter int STREAM_W = 32
);
  logic [STREAM_W-1:0] tdata;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/azimuth_sweep_scheduler.sv
// Steps the azimuth signal generator through one revolution: fills a shadow
// bitmap from the stream and swaps it onto data at every azimuth change pulse.
module azimuth_sweep_scheduler #(
  parameter int SIZE      = 3200,
  parameter int STREAM_W  = 32,
  parameter int ACP_COUNT = 4096,
  localparam int AZ_BITS  = (ACP_COUNT > 2) ? $clog2(ACP_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 acp,
  input  logic                 arp,
  input  logic                 clr_err,
  azimuth_sweep_scheduler_if.slave s,
  output logic                 sig_en,
  output logic                 trig,
  output logic [SIZE-1:0]      data,
  output logic [AZ_BITS-1:0]   azimuth,
  output logic                 underrun,
  output logic [15:0]          underrun_cnt,
  output logic                 framing_err,
  output logic [1:0]           dbg_state
);
  localparam int WORDS  = SIZE / STREAM_W;
  localparam int K_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [K_BITS-1:0]  K_LAST  = K_BITS'(WORDS - 1);
  localparam logic [AZ_BITS-1:0] AZ_LAST = AZ_BITS'(ACP_COUNT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [2:0]         acp_sync, arp_sync;
  logic               acp_edge, arp_edge, hs;
  logic [SIZE-1:0]    shadow;
  logic               full_q;
  logic [K_BITS-1:0]  k_q;
  logic [AZ_BITS-1:0] az_cnt, az_base;
  logic [15:0]        cnt_base;

  // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
  assign acp_edge = acp_sync[1] & ~acp_sync[2];
  assign arp_edge = arp_sync[1] & ~arp_sync[2];
  assign hs       = s.tvalid & s.tready;
  // A north reference coinciding with an ACP restarts the count before it is used.
  assign az_base  = arp_edge ? '0 : az_cnt;
  assign cnt_base = clr_err ? 16'd0 : underrun_cnt;

  assign sig_en    = (state_q == RUN);
  assign s.tready  = (state_q != IDLE) && !full_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = ARMED;
      ARMED:   if (arp_edge) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acp_sync     <= '0;
      arp_sync     <= '0;
      trig         <= 1'b0;
      data         <= '0;
      shadow       <= '0;
      full_q       <= 1'b0;
      k_q          <= '0;
      az_cnt       <= '0;
      azimuth      <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      framing_err  <= 1'b0;
    end else begin
      acp_sync <= {acp_sync[1:0], acp};
      arp_sync <= {arp_sync[1:0], arp};
      trig     <= 1'b0;
      if (clr_err) begin
        underrun     <= 1'b0;
        underrun_cnt <= '0;
        framing_err  <= 1'b0;
      end
      if (!en) begin
        data   <= '0;
        full_q <= 1'b0;
        k_q    <= '0;
      end else begin
        if (arp_edge && state_q != IDLE) az_cnt <= '0;
        if (state_q == RUN && acp_edge) begin
          trig    <= 1'b1;
          azimuth <= az_base;
          az_cnt  <= (az_base == AZ_LAST) ? '0 : az_base + 1'b1;
          if (full_q) begin
            data   <= shadow;
            full_q <= 1'b0;
          end else begin
            // Blank this azimuth; the partial fill keeps going for the next one.
            data         <= '0;
            underrun     <= 1'b1;
            underrun_cnt <= (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
          end
        end
        if (hs) begin
          if (s.tlast && k_q != K_LAST) begin
            framing_err <= 1'b1;
            k_q         <= '0;
          end else begin
            shadow[k_q*STREAM_W +: STREAM_W] <= s.tdata;
            if (k_q == K_LAST) begin
              k_q    <= '0;
              full_q <= 1'b1;
              if (!s.tlast) framing_err <= 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_azimuth_sweep_scheduler.sv
// Directed-plus-random bench for azimuth_sweep_scheduler against a frame-level
// reference model (accepted words queue, azimuth counter, error flags).
module tb_azimuth_sweep_scheduler;
  localparam int SIZE  = 3200;
  localparam int SW    = 32;
  localparam int ACPN  = 64;
  localparam int AZB   = 6;
  localparam int WORDS = SIZE / SW;

  logic clk = 1'b0;
  logic rst, en, acp, arp, clr_err;
  logic sig_en, trig, underrun, framing_err;
  logic [SIZE-1:0] data;
  logic [AZB-1:0]  azimuth;
  logic [15:0]     underrun_cnt;
  logic [1:0]      dbg_state;

  azimuth_sweep_scheduler_if #(.STREAM_W(SW)) s_if ();

  azimuth_sweep_scheduler #(.SIZE(SIZE), .STREAM_W(SW), .ACP_COUNT(ACPN)) dut (
    .clk(clk), .rst(rst), .en(en), .acp(acp), .arp(arp), .clr_err(clr_err),
    .s(s_if), .sig_en(sig_en), .trig(trig), .data(data), .azimuth(azimuth),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .framing_err(framing_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: exp_q holds the words accepted into the current frame.
  logic [SW-1:0]   exp_q[$];
  logic [SIZE-1:0] m_data;
  int              m_az, m_azimuth, m_ucnt, m_mode;  // m_mode: 0 idle, 1 armed, 2 running
  bit              m_full, m_under, m_framing;

  function automatic logic [SIZE-1:0] pack_q();
    logic [SIZE-1:0] v = '0;
    for (int i = 0; i < exp_q.size(); i++) v[i*SW +: SW] = exp_q[i];
    return v;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < WORDS; i++)
      if (data[i*SW +: SW] !== m_data[i*SW +: SW]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag);
    int fd;
    checks++;
    assert (data === m_data) else begin
      errors++;
      fd = first_diff();
      $error("FAIL %s: data word %0d observed=%h expected=%h", tag, fd,
             data[fd*SW +: SW], m_data[fd*SW +: SW]);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sig_en"}, sig_en, m_mode == 2);
    check({tag, ".tready"}, s_if.tready, (m_mode != 0) && !m_full);
    check({tag, ".azimuth"}, azimuth, m_azimuth);
    check({tag, ".underrun"}, underrun, m_under);
    check({tag, ".underrun_cnt"}, underrun_cnt, m_ucnt);
    check({tag, ".framing_err"}, framing_err, m_framing);
    check_data({tag, ".data"});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_data = '0; m_az = 0; m_azimuth = 0; m_ucnt = 0; m_mode = 0;
    m_full = 0; m_under = 0; m_framing = 0;
  endtask

  task automatic send_word(input logic [SW-1:0] w, input bit last, input bit clr);
    bit done = 0;
    bit rdy;
    s_if.tdata = w; s_if.tlast = last; s_if.tvalid = 1'b1; clr_err = clr;
    for (int t = 0; t < 50 && !done; t++) begin
      rdy = s_if.tready;
      @(posedge clk); #1;
      clr_err = 1'b0;
      if (rdy) done = 1;
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    check("handshake_timeout", done, 1);
    if (clr) begin m_under = 0; m_framing = 0; m_ucnt = 0; end
    if (done) begin
      if (last && exp_q.size() < WORDS - 1) begin
        m_framing = 1;
        exp_q.delete();
      end else begin
        exp_q.push_back(w);
        if (exp_q.size() == WORDS) begin
          m_full = 1;
          if (!last) m_framing = 1;
        end
      end
    end
    check("word.framing_err", framing_err, m_framing);
    check("word.tready", s_if.tready, !m_full);
  endtask

  task automatic send_part(input int from, input int to, input bit idx_data, input int last_at);
    for (int k = from; k <= to; k++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      send_word(idx_data ? SW'(k) : SW'($urandom), k == last_at, 1'b0);
    end
  endtask

  task automatic pulse(input string tag, input bit do_acp, input bit do_arp);
    bit was_run;
    acp = do_acp; arp = do_arp;
    @(posedge clk); #1; check({tag, ".trig_e1"}, trig, 0);
    @(posedge clk); #1; check({tag, ".trig_e2"}, trig, 0);
    @(posedge clk); #1;
    was_run = (m_mode == 2);
    if (was_run) begin
      if (do_arp) m_az = 0;
      if (do_acp) begin
        m_azimuth = m_az;
        m_az = (m_az + 1) % ACPN;
        if (m_full) begin
          m_data = pack_q(); exp_q.delete(); m_full = 0;
        end else begin
          m_data = '0; m_under = 1;
          if (m_ucnt < 65535) m_ucnt++;
        end
      end
    end else if (m_mode == 1 && do_arp) begin
      m_mode = 2; m_az = 0;
    end
    check({tag, ".trig_e3"}, trig, do_acp && was_run);
    check_all(tag);
    acp = 1'b0; arp = 1'b0;
    @(posedge clk); #1; check({tag, ".trig_e4"}, trig, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit v);
    en = v;
    @(posedge clk); #1;
    if (!v) begin
      m_mode = 0; m_data = '0; exp_q.delete(); m_full = 0;
    end else if (m_mode == 0) m_mode = 1;
    check_all(v ? "en_on" : "en_off");
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    m_under = 0; m_framing = 0; m_ucnt = 0;
    check_all("clr_err");
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; acp = 1'b0; arp = 1'b0; clr_err = 1'b0;
    s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.trig", trig, 0);
    rst = 1'b0;

    // First frame: word k = k, presented as azimuth 0.
    set_en(1'b1);
    pulse("arp_start", 1'b0, 1'b1);
    send_part(0, WORDS - 1, 1'b1, WORDS - 1);
    pulse("first_acp", 1'b1, 1'b0);
    check("first.data_lo", data[31:0], 0);
    check("first.data_hi", data[SIZE-1 -: 32], WORDS - 1);
    check("first.azimuth", azimuth, 0);

    // Full revolution plus one, preloaded each time: azimuth 1..ACPN-1 then 0.
    for (int i = 1; i <= ACPN; i++) begin
      send_part(0, WORDS - 1, 1'b0, WORDS - 1);
      pulse("sweep", 1'b1, 1'b0);
    end
    check("wrap.azimuth", azimuth, 0);
    check("wrap.no_error", {underrun, framing_err}, 0);

    // Underrun with half a frame, then completion of the same frame.
    send_part(0, WORDS / 2 - 1, 1'b0, WORDS - 1);
    pulse("underrun", 1'b1, 1'b0);
    check("underrun.cnt", underrun_cnt, 1);
    send_part(WORDS / 2, WORDS - 1, 1'b0, WORDS - 1);
    pulse("after_underrun", 1'b1, 1'b0);

    // Early TLAST discards the partial frame; next frame is clean.
    send_part(0, 40, 1'b0, 40);
    check("early_last.flag", framing_err, 1);
    send_part(0, WORDS - 1, 1'b0, WORDS - 1);
    pulse("after_early_last", 1'b1, 1'b0);
    pulse_clr();

    // Missing TLAST still yields a full frame.
    send_part(0, WORDS - 1, 1'b0, -1);
    pulse("missing_last", 1'b1, 1'b0);
    pulse_clr();

    // Clear and new framing error on the same edge: the error wins.
    send_part(0, 9, 1'b0, WORDS - 1);
    send_word(SW'($urandom), 1'b1, 1'b1);
    check("clr_vs_err.flag", framing_err, 1);
    pulse_clr();

    // Simultaneous ARP and ACP with a full shadow.
    send_part(0, WORDS - 1, 1'b0, WORDS - 1);
    pulse("arp_acp", 1'b1, 1'b1);
    check("arp_acp.azimuth", azimuth, 0);
    send_part(0, WORDS - 1, 1'b0, WORDS - 1);
    pulse("after_arp_acp", 1'b1, 1'b0);
    check("after_arp_acp.azimuth", azimuth, 1);

    // Disable mid-fill.
    send_part(0, 29, 1'b0, WORDS - 1);
    set_en(1'b0);
    check("disable.data", data === '0, 1);

    // Re-arm, partially fill, then asynchronous reset mid-cycle.
    set_en(1'b1);
    pulse("rearm_arp", 1'b0, 1'b1);
    send_part(0, 19, 1'b0, WORDS - 1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset.trig", trig, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    en = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
